// File: rtl/accum_stage_pkg.sv
// Shared types for the online-softmax output accumulator: element/vector types,
// saturation bounds and the accumulator FSM state encoding.
package accum_stage_pkg;

    localparam int INT_W   = 8;
    localparam int VEC_LEN = 4;

    typedef logic signed [INT_W-1:0] INT_T;
    typedef INT_T [VEC_LEN-1:0]      STAR_VECTOR_T;

    localparam INT_T INT_MAX = {1'b0, {(INT_W-1){1'b1}}};
    localparam INT_T INT_MIN = {1'b1, {(INT_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FLUSH = 2'd2
    } ACCUM_STATE_T;

endpackage

// File: rtl/accum_stage_sat_add.sv
// Single-element signed adder; clamps to [INT_MIN, INT_MAX] when
// ACCUM_SATURATE_EN is defined, otherwise wraps modulo 2^INT_W.
module sat_add_int
    import accum_stage_pkg::*;
(
    input  INT_T a,
    input  INT_T b,
    output INT_T y
);

`ifdef ACCUM_SATURATE_EN
    logic signed [INT_W:0] sum;

    assign sum = {a[INT_W-1], a} + {b[INT_W-1], b};

    // Overflow shows up as the guard bit disagreeing with the result sign bit.
    always_comb begin
        y = sum[INT_W-1:0];
        if (sum[INT_W] != sum[INT_W-1])
            y = sum[INT_W] ? INT_MIN : INT_MAX;
    end
`else
    assign y = a + b;
`endif

endmodule

// File: rtl/accum_stage.sv
// Running output-row accumulator of the online-softmax datapath; holds finished
// rows for downstream under valid/ready. Saturating adds under ACCUM_SATURATE_EN.
module accum_stage
    import accum_stage_pkg::*;
#(
    parameter int N_KEYS = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         vld_in,
    output logic         rdy_out,
    input  logic         last_in,
    input  STAR_VECTOR_T acc_scaled_in,
    input  STAR_VECTOR_T v_scaled_in,
    output STAR_VECTOR_T acc_out,
    output logic         vld_out,
    input  logic         rdy_in,
    output STAR_VECTOR_T o_out,
    output logic         row_err
);

    localparam int CNT_W = (N_KEYS > 1) ? $clog2(N_KEYS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_KEYS - 1);

    ACCUM_STATE_T     state;
    logic [CNT_W-1:0] cnt;
    STAR_VECTOR_T     acc;
    STAR_VECTOR_T     sum_vec;
    logic             accept;
    logic             first_beat;
    logic             row_end;

    for (genvar i = 0; i < VEC_LEN; i++) begin : g_add
        sat_add_int u_add (
            .a(acc_scaled_in[i]),
            .b(v_scaled_in[i]),
            .y(sum_vec[i])
        );
    end

    assign rdy_out    = (state != FLUSH) || rdy_in;
    assign accept     = vld_in && rdy_out;
    // Any beat outside ACCUM starts a fresh row, so the prior accumulator is zero.
    assign first_beat = (state != ACCUM);
    assign row_end    = last_in || (cnt == LAST_CNT);

    assign acc_out = acc;
    assign o_out   = acc;
    assign vld_out = (state == FLUSH);

    // A beat accepted in the flush cycle both drains the old row and opens the next.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            acc     <= '0;
            row_err <= 1'b0;
        end else begin
            row_err <= 1'b0;
            if (accept) begin
                acc     <= first_beat ? v_scaled_in : sum_vec;
                row_err <= row_end && last_in && (cnt != LAST_CNT);
                if (row_end) begin
                    state <= FLUSH;
                    cnt   <= '0;
                end else begin
                    state <= ACCUM;
                    cnt   <= first_beat ? CNT_W'(1) : cnt + 1'b1;
                end
            end else if (state == FLUSH && rdy_in) begin
                state <= IDLE;
                acc   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_accum_stage.sv
// Table-driven self-checking bench for accum_stage (N_KEYS = 4); expected
// overflow results follow ACCUM_SATURATE_EN.
module tb_accum_stage;
    import accum_stage_pkg::*;

    typedef struct {
        logic vld;
        logic last;
        logic rdyi;
        int   as_val;
        int   v_val;
        int   exp_acc;
        logic exp_vld;
        logic exp_rdy;
        logic exp_err;
    } vec_t;

`ifdef ACCUM_SATURATE_EN
    localparam int POS_OVF = 127;
    localparam int NEG_OVF = -128;
`else
    localparam int POS_OVF = -56;
    localparam int NEG_OVF = 56;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         vld_in;
    logic         rdy_out;
    logic         last_in;
    STAR_VECTOR_T acc_scaled_in;
    STAR_VECTOR_T v_scaled_in;
    STAR_VECTOR_T acc_out;
    logic         vld_out;
    logic         rdy_in;
    STAR_VECTOR_T o_out;
    logic         row_err;

    int   errors = 0;
    int   checks = 0;
    vec_t tbl[$];

    accum_stage #(.N_KEYS(4)) dut (
        .clk(clk),
        .rst(rst),
        .vld_in(vld_in),
        .rdy_out(rdy_out),
        .last_in(last_in),
        .acc_scaled_in(acc_scaled_in),
        .v_scaled_in(v_scaled_in),
        .acc_out(acc_out),
        .vld_out(vld_out),
        .rdy_in(rdy_in),
        .o_out(o_out),
        .row_err(row_err)
    );

    always #5 clk = ~clk;

    function automatic STAR_VECTOR_T rep(input int x);
        STAR_VECTOR_T r;
        for (int i = 0; i < VEC_LEN; i++) r[i] = INT_T'(x);
        return r;
    endfunction

    task automatic addRow(input logic vld, input logic last, input logic rdyi,
                          input int as_val, input int v_val, input int exp_acc,
                          input logic exp_vld, input logic exp_rdy, input logic exp_err);
        vec_t r;
        r.vld = vld; r.last = last; r.rdyi = rdyi;
        r.as_val = as_val; r.v_val = v_val; r.exp_acc = exp_acc;
        r.exp_vld = exp_vld; r.exp_rdy = exp_rdy; r.exp_err = exp_err;
        tbl.push_back(r);
    endtask

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // Drive one cycle of inputs, clock it, then sample just after the edge.
    task automatic applyStimulus(input logic vld, input logic last, input logic rdyi,
                                 input STAR_VECTOR_T as_vec, input STAR_VECTOR_T v_vec);
        vld_in        = vld;
        last_in       = last;
        rdy_in        = rdyi;
        acc_scaled_in = as_vec;
        v_scaled_in   = v_vec;
        @(posedge clk);
        #1;
    endtask

    task automatic checkAll(input string tag, input int exp_acc, input logic ev,
                            input logic er, input logic ee);
        checkOutput({tag, " acc_out"}, 64'(acc_out), 64'(rep(exp_acc)));
        checkOutput({tag, " o_out"},   64'(o_out),   64'(rep(exp_acc)));
        checkOutput({tag, " vld_out"}, 64'(vld_out), 64'(ev));
        checkOutput({tag, " rdy_out"}, 64'(rdy_out), 64'(er));
        checkOutput({tag, " row_err"}, 64'(row_err), 64'(ee));
    endtask

    initial begin
        // Full 4-beat row of ones with looped-back accumulator, then held flush.
        addRow(1, 0, 0,   0,   1,   1, 0, 1, 0);
        addRow(1, 0, 0,   1,   1,   2, 0, 1, 0);
        addRow(1, 0, 0,   2,   1,   3, 0, 1, 0);
        addRow(1, 0, 0,   3,   1,   4, 1, 0, 0);
        addRow(1, 0, 0,   4,   9,   4, 1, 0, 0);
        addRow(0, 0, 1,   0,   0,   0, 0, 1, 0);
        // Early last_in on beat 2, flush held for 5 cycles with a beat offered.
        addRow(1, 0, 0,   0,   1,   1, 0, 1, 0);
        addRow(1, 1, 0,   1,   1,   2, 1, 0, 1);
        addRow(1, 0, 0,  50,   5,   2, 1, 0, 0);
        addRow(1, 0, 0,  50,   5,   2, 1, 0, 0);
        addRow(1, 0, 0,  50,   5,   2, 1, 0, 0);
        addRow(1, 0, 0,  50,   5,   2, 1, 0, 0);
        addRow(1, 0, 0,  50,   5,   2, 1, 0, 0);
        addRow(1, 0, 1,  50,   7,   7, 0, 1, 0);
        addRow(1, 0, 1,   7,   1,   8, 0, 1, 0);
        addRow(1, 0, 1,   8,   1,   9, 0, 1, 0);
        addRow(1, 0, 1,   9,   1,  10, 1, 1, 0);
        // Flush overlapped with the first beat of the next row.
        addRow(1, 0, 1,   0,   3,   3, 0, 1, 0);
        addRow(1, 1, 1, 100, 100, POS_OVF, 1, 1, 1);
        addRow(1, 1, 1,   0,   5,   5, 1, 1, 1);
        addRow(0, 0, 1,   0,   0,   0, 0, 1, 0);
        addRow(1, 0, 0,   0,   1,   1, 0, 1, 0);
        addRow(1, 1, 0, -100, -100, NEG_OVF, 1, 0, 1);
        addRow(0, 0, 1,   0,   0,   0, 0, 1, 0);

        rst = 1'b1;
        applyStimulus(0, 0, 0, rep(0), rep(0));
        applyStimulus(0, 0, 0, rep(0), rep(0));
        checkAll("reset", 0, 0, 1, 0);
        rst = 1'b0;

        foreach (tbl[k]) begin
            applyStimulus(tbl[k].vld, tbl[k].last, tbl[k].rdyi,
                          rep(tbl[k].as_val), rep(tbl[k].v_val));
            checkAll($sformatf("row%0d", k), tbl[k].exp_acc, tbl[k].exp_vld,
                     tbl[k].exp_rdy, tbl[k].exp_err);
        end

        // Reset in the middle of a row discards it.
        applyStimulus(1, 0, 0, rep(0), rep(3));
        applyStimulus(1, 0, 0, rep(3), rep(3));
        checkAll("prerst", 6, 0, 1, 0);
        rst = 1'b1;
        applyStimulus(1, 0, 0, rep(6), rep(3));
        checkAll("midrst", 0, 0, 1, 0);
        rst = 1'b0;

        for (int b = 1; b <= 4; b++) begin
            applyStimulus(1, 0, 0, acc_out, rep(3));
            checkAll($sformatf("fresh%0d", b), 3 * b, b == 4, b != 4, 0);
        end
        applyStimulus(0, 0, 1, rep(0), rep(0));
        checkAll("drain", 0, 0, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/accum_stage.md
# accum_stage

Output accumulator stage directly downstream of `expmul_stage` in the online-softmax datapath. It keeps the running output row `acc`. Each accepted beat replaces it with the elementwise sum of two exp-scaled vectors: the rescaled previous accumulator and the exp-weighted value vector, both produced by `expmul_stage` instances. After the last key of a row it presents the finished vector downstream under valid/ready, then clears for the next row.

## Interface
- `N_KEYS`, default 64: keys per query row; the beat counter is `$clog2(N_KEYS)` bits wide.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `vld_in`  in  1  upstream beat valid.
- `rdy_out`  out  1  this stage can accept a beat.
- `last_in`  in  1  beat is the final key of its row.
- `acc_scaled_in`  in  STAR_VECTOR_T  exp(m_old−m_new)·acc from the feedback `expmul_stage`.
- `v_scaled_in`  in  STAR_VECTOR_T  exp(s−m_new)·v from the value `expmul_stage`.
- `acc_out`  out  STAR_VECTOR_T  current accumulator, fed back to the rescaling `expmul_stage`.
- `vld_out`  out  1  finished row valid.
- `rdy_in`  in  1  downstream ready.
- `o_out`  out  STAR_VECTOR_T  finished row; equal to `acc`.
- `row_err`  out  1  one-cycle pulse when `last_in` arrives before beat N_KEYS−1.

## Operation
- States are IDLE (no beat yet this row), ACCUM (row in progress) and FLUSH (row complete, held for downstream).
- Accept condition: `vld_in && rdy_out`.
- IDLE, beat accepted:
  - `acc <= v_scaled_in`; `acc_scaled_in` is ignored because the prior accumulator is zero.
  - `cnt <= 1`; go to ACCUM.
- ACCUM, beat accepted:
  - Each element updates as `acc[i] <= sat(acc_scaled_in[i] + v_scaled_in[i])`.
  - `cnt` increments.
- Row end is a beat accepted with `last_in == 1` or with `cnt == N_KEYS−1`. It applies in IDLE and in ACCUM, so a row of one key goes straight to FLUSH.
  - The state goes to FLUSH after the update; `cnt` is cleared.
- `row_err` pulses on the cycle after the row end when `last_in` was set and `cnt != N_KEYS−1`. The row still ends normally.
- FLUSH:
  - `vld_out = 1` and `o_out = acc`, both held stable until `rdy_in`.
  - On `rdy_in` the stage goes to IDLE and `acc` becomes zero.
- Simultaneous flush and new beat:
  - In FLUSH, `rdy_out = rdy_in`.
  - A beat accepted in the flush cycle is the first beat of the new row: `acc <= v_scaled_in`, `cnt <= 1`, and the next state is ACCUM. If that beat also carries `last_in` (or N_KEYS == 1), the next state is FLUSH.
- Arithmetic:
  - Elements are signed INT_T.
  - Sums are computed one bit wider, then clamped to [INT_MIN, INT_MAX] when saturation is enabled (see Configuration).
- `acc_out` is continuously `acc`.

## Timing
- Reset values: state IDLE, `acc = 0`, `cnt = 0`, `vld_out = 0`, `rdy_out = 1`, `row_err = 0`, `o_out = 0`, `acc_out = 0`.
- Accumulate latency: a beat accepted at edge t is visible on `acc_out` after edge t.
- Finished-row latency: if the last beat is accepted at edge t, `vld_out = 1` after edge t.
- Throughput:
  - One beat per cycle in IDLE and ACCUM.
  - No bubble between rows while `rdy_in` is high.
- `rdy_out` is 1 in IDLE and ACCUM regardless of `rdy_in`. It is combinational from state and `rdy_in` only, with no path from `vld_in`.
- When `vld_in = 1` and `rdy_out = 0`, no state changes; upstream holds its beat.
- Reset asserted mid-row or mid-FLUSH discards the row and restores all reset values on the next edge.

## Configuration
- `ACCUM_SATURATE_EN`:
  - Defined: per-element adds clamp to [INT_MIN, INT_MAX].
  - Undefined: adds wrap modulo 2^INT_W, and the saturation logic is absent.

## Structure
- The shared package holds `INT_T`, `INT_W`, `VEC_LEN`, `STAR_VECTOR_T`, `INT_MAX`, `INT_MIN` and the `ACCUM_STATE_T` enum (IDLE, ACCUM, FLUSH).
- One sub-module, `sat_add_int`: a combinational single-element add that saturates under `ACCUM_SATURATE_EN`. It is instantiated VEC_LEN times via generate.
- The FSM, counter and vector register live in `accum_stage`.

## Test plan
- With INT_W = 8 and N_KEYS = 4, feed 4 beats with `v_scaled_in` elements all 1 and `acc_scaled_in = acc_out` looped back.
  - Required: `vld_out` after the 4th edge with every `o_out` element = 4; `row_err` stays 0.
- Send `last_in` on beat 2.
  - Required: FLUSH with elements = 2, and a 1-cycle `row_err` pulse.
- Hold `rdy_in = 0` for 5 cycles in FLUSH.
  - Required: `o_out` stable, `rdy_out = 0`, and offered beats are not consumed.
  - When `rdy_in` rises with a beat of value 7 present: the next `acc` = 7 and the state is ACCUM.
- Send `acc_scaled_in = 100` and `v_scaled_in = 100`.
  - With `ACCUM_SATURATE_EN`: result 127.
  - Without it: result −56.
  - Repeat with −100 + −100: −128 saturated, 56 wrapped.
- Assert `rst` after beat 2 of a row.
  - Required: all outputs return to reset values.
  - A fresh 4-beat row of 3s yields `o_out` = 12.
